// File: rtl/fmul_s2_pipe.sv
// fmul_s2_pipe: registered, flow-controlled boundary between fmul stage 1
// (exponent / special-case / significand product) and stage 2
// (normalise / round). A 2-entry skid buffer keeps one transfer per cycle
// while in_ready_o is a pure register output.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               synchronous flush, drops every held bundle
//   in_valid_i/in_ready_o upstream handshake
//   in_*                  stage-1 result bundle plus user tag
//   out_valid_o/out_ready_i downstream handshake
//   out_*                 registered copy of the bundle at the head
//   occupancy_o           bundles currently held (0..2)
module fmul_s2_pipe #(
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned PRECISION = 24,
  parameter int unsigned TAGWIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [4:0]             in_special_case_i,
  input  logic                   in_early_overflow_i,
  input  logic                   in_prod_sign_i,
  input  logic [EXPWIDTH:0]      in_shift_amt_i,
  input  logic [EXPWIDTH:0]      in_exp_shifted_i,
  input  logic                   in_may_be_subnormal_i,
  input  logic [2:0]             in_rm_i,
  input  logic [2*PRECISION-1:0] in_prod_i,
  input  logic [TAGWIDTH-1:0]    in_tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4:0]             out_special_case_o,
  output logic                   out_early_overflow_o,
  output logic                   out_prod_sign_o,
  output logic [EXPWIDTH:0]      out_shift_amt_o,
  output logic [EXPWIDTH:0]      out_exp_shifted_o,
  output logic                   out_may_be_subnormal_o,
  output logic [2:0]             out_rm_o,
  output logic [2*PRECISION-1:0] out_prod_o,
  output logic [TAGWIDTH-1:0]    out_tag_o,
  output logic [1:0]             occupancy_o
);

  localparam int unsigned PW = 5 + 1 + 1 + 2 * (EXPWIDTH + 1) + 1 + 3
                             + 2 * PRECISION + TAGWIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   main_q, skid_q, in_pl;
  logic            main_v, skid_v;
  logic            in_fire, out_fire;
  logic            load_main_in, load_main_skid, load_skid_in;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);

  assign in_ready_o  = ~skid_v;
  assign out_valid_o = main_v;
  assign occupancy_o = {1'b0, main_v} + {1'b0, skid_v};

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  assign in_pl = {in_special_case_i, in_early_overflow_i, in_prod_sign_i,
                  in_shift_amt_i, in_exp_shifted_i, in_may_be_subnormal_i,
                  in_rm_i, in_prod_i, in_tag_i};

  assign {out_special_case_o, out_early_overflow_o, out_prod_sign_o,
          out_shift_amt_o, out_exp_shifted_o, out_may_be_subnormal_o,
          out_rm_o, out_prod_o, out_tag_o} = main_q;

  // Flush wins over any handshake in the same cycle; payload loads are
  // suppressed too so a dropped bundle never reaches the registers.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid_in = 1'b1;
            state_d      = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_pl;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= in_pl;
      end
    end
  end

endmodule

// File: tb/tb_fmul_s2_pipe.sv
// Self-checking bench for fmul_s2_pipe: a directed vector table, hand-written
// flush / asynchronous-reset sequences, randomized traffic against a
// two-deep FIFO reference model, and a wide-parameter instance.
module tb_fmul_s2_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // ---------------- default-parameter instance ----------------
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_sc, out_sc;
  logic        in_eo, out_eo, in_ps, out_ps, in_msub, out_msub;
  logic [8:0]  in_sa, out_sa, in_es, out_es;
  logic [2:0]  in_rm, out_rm;
  logic [47:0] in_prod, out_prod;
  logic [7:0]  in_tag, out_tag;
  logic [1:0]  occupancy;

  fmul_s2_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_special_case_i(in_sc), .in_early_overflow_i(in_eo),
    .in_prod_sign_i(in_ps), .in_shift_amt_i(in_sa),
    .in_exp_shifted_i(in_es), .in_may_be_subnormal_i(in_msub),
    .in_rm_i(in_rm), .in_prod_i(in_prod), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_special_case_o(out_sc), .out_early_overflow_o(out_eo),
    .out_prod_sign_o(out_ps), .out_shift_amt_o(out_sa),
    .out_exp_shifted_o(out_es), .out_may_be_subnormal_o(out_msub),
    .out_rm_o(out_rm), .out_prod_o(out_prod), .out_tag_o(out_tag),
    .occupancy_o(occupancy)
  );

  // ---------------- wide-parameter instance ----------------
  logic         w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [4:0]   w_in_sc, w_out_sc;
  logic         w_in_eo, w_out_eo, w_in_ps, w_out_ps, w_in_msub, w_out_msub;
  logic [11:0]  w_in_sa, w_out_sa, w_in_es, w_out_es;
  logic [2:0]   w_in_rm, w_out_rm;
  logic [105:0] w_in_prod, w_out_prod;
  logic [0:0]   w_in_tag, w_out_tag;
  logic [1:0]   w_occupancy;

  fmul_s2_pipe #(.EXPWIDTH(11), .PRECISION(53), .TAGWIDTH(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush_i(w_flush),
    .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .in_special_case_i(w_in_sc), .in_early_overflow_i(w_in_eo),
    .in_prod_sign_i(w_in_ps), .in_shift_amt_i(w_in_sa),
    .in_exp_shifted_i(w_in_es), .in_may_be_subnormal_i(w_in_msub),
    .in_rm_i(w_in_rm), .in_prod_i(w_in_prod), .in_tag_i(w_in_tag),
    .out_valid_o(w_out_valid), .out_ready_i(w_out_ready),
    .out_special_case_o(w_out_sc), .out_early_overflow_o(w_out_eo),
    .out_prod_sign_o(w_out_ps), .out_shift_amt_o(w_out_sa),
    .out_exp_shifted_o(w_out_es), .out_may_be_subnormal_o(w_out_msub),
    .out_rm_o(w_out_rm), .out_prod_o(w_out_prod), .out_tag_o(w_out_tag),
    .occupancy_o(w_occupancy)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  sc;
    logic        eo;
    logic        ps;
    logic [8:0]  sa;
    logic [8:0]  es;
    logic        msub;
    logic [2:0]  rm;
    logic [47:0] prod;
    logic [7:0]  tag;
  } bnd_t;

  typedef struct packed {
    logic [4:0]   sc;
    logic         eo;
    logic         ps;
    logic [11:0]  sa;
    logic [11:0]  es;
    logic         msub;
    logic [2:0]   rm;
    logic [105:0] prod;
    logic [0:0]   tag;
  } wbnd_t;

  // Each model is simply an ordered list of accepted bundles, at most 2 deep.
  bnd_t  q[$];
  wbnd_t wq[$];

  typedef struct {
    logic        v;
    logic        rdy;
    logic        fl;
    logic [7:0]  tag;
    logic [47:0] prod;
    logic        ev;
    logic        er;
    logic [1:0]  eocc;
    logic [7:0]  etag;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bnd_t rand_bnd();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[$bits(bnd_t)-1:0];
  endfunction

  // Drive one cycle's inputs and compare outputs against the model head.
  task automatic drive_check(input logic v, input logic rdy, input logic fl,
                             input bnd_t b);
    bnd_t act;
    in_valid = v; out_ready = rdy; flush = fl;
    {in_sc, in_eo, in_ps, in_sa, in_es, in_msub, in_rm, in_prod, in_tag} = b;
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("occupancy", occupancy, q.size());
    if (q.size() > 0) begin
      act = {out_sc, out_eo, out_ps, out_sa, out_es, out_msub, out_rm,
             out_prod, out_tag};
      chk("out_tag", out_tag, q[0].tag);
      chk("payload", act, q[0]);
    end
  endtask

  task automatic advance(input logic v, input logic rdy, input logic fl,
                         input bnd_t b);
    logic acc, pop;
    acc = v && (q.size() < 2);
    pop = rdy && (q.size() > 0);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic rdy, input logic fl,
                      input bnd_t b);
    drive_check(v, rdy, fl, b);
    advance(v, rdy, fl, b);
  endtask

  task automatic wstep(input logic v, input logic rdy, input wbnd_t b);
    logic acc, pop;
    wbnd_t act;
    w_in_valid = v; w_out_ready = rdy; w_flush = 1'b0;
    {w_in_sc, w_in_eo, w_in_ps, w_in_sa, w_in_es, w_in_msub, w_in_rm,
     w_in_prod, w_in_tag} = b;
    #1;
    chk("w_out_valid", w_out_valid, wq.size() > 0);
    chk("w_in_ready", w_in_ready, wq.size() < 2);
    chk("w_occupancy", w_occupancy, wq.size());
    if (wq.size() > 0) begin
      act = {w_out_sc, w_out_eo, w_out_ps, w_out_sa, w_out_es, w_out_msub,
             w_out_rm, w_out_prod, w_out_tag};
      chk("w_prod", w_out_prod, wq[0].prod);
      chk("w_payload", act, wq[0]);
    end
    acc = v && (wq.size() < 2);
    pop = rdy && (wq.size() > 0);
    if (pop) void'(wq.pop_front());
    if (acc) wq.push_back(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mkv(input logic v, input logic rdy, input logic fl,
                               input logic [7:0] tag, input logic [47:0] prod,
                               input logic ev, input logic er,
                               input logic [1:0] eocc, input logic [7:0] etag);
    vec_t t;
    t.v = v; t.rdy = rdy; t.fl = fl; t.tag = tag; t.prod = prod;
    t.ev = ev; t.er = er; t.eocc = eocc; t.etag = etag;
    return t;
  endfunction

  initial begin
    bnd_t  b;
    wbnd_t wb;

    // Expected outputs are those seen during the cycle the inputs are driven.
    tbl[0]  = mkv(0, 1, 0, 8'h00, 48'h0,            0, 1, 0, 8'h00);
    tbl[1]  = mkv(1, 1, 0, 8'h5A, 48'h123456789ABC, 0, 1, 0, 8'h00);
    tbl[2]  = mkv(0, 1, 0, 8'h00, 48'h0,            1, 1, 1, 8'h5A);
    tbl[3]  = mkv(0, 1, 0, 8'h00, 48'h0,            0, 1, 0, 8'h00);
    tbl[4]  = mkv(1, 0, 0, 8'h01, 48'h0,            0, 1, 0, 8'h00);
    tbl[5]  = mkv(1, 0, 0, 8'h02, 48'h0,            1, 1, 1, 8'h01);
    tbl[6]  = mkv(1, 0, 0, 8'h03, 48'h0,            1, 0, 2, 8'h01);
    tbl[7]  = mkv(1, 0, 0, 8'h03, 48'h0,            1, 0, 2, 8'h01);
    tbl[8]  = mkv(1, 1, 0, 8'h03, 48'h0,            1, 0, 2, 8'h01);
    tbl[9]  = mkv(1, 1, 0, 8'h03, 48'h0,            1, 1, 1, 8'h02);
    tbl[10] = mkv(0, 1, 0, 8'h00, 48'h0,            1, 1, 1, 8'h03);
    tbl[11] = mkv(0, 1, 0, 8'h00, 48'h0,            0, 1, 0, 8'h00);
    tbl[12] = mkv(1, 0, 0, 8'h07, 48'h0,            0, 1, 0, 8'h00);
    tbl[13] = mkv(1, 0, 0, 8'h08, 48'h0,            1, 1, 1, 8'h07);
    tbl[14] = mkv(1, 0, 1, 8'h09, 48'h0,            1, 0, 2, 8'h07);
    tbl[15] = mkv(0, 1, 0, 8'h00, 48'h0,            0, 1, 0, 8'h00);
    tbl[16] = mkv(1, 1, 0, 8'h09, 48'h0,            0, 1, 0, 8'h00);
    tbl[17] = mkv(1, 0, 1, 8'h0A, 48'h0,            1, 1, 1, 8'h09);
    tbl[18] = mkv(0, 1, 0, 8'h00, 48'h0,            0, 1, 0, 8'h00);

    rst_n = 1'b0;
    {flush, in_valid, out_ready} = '0;
    {in_sc, in_eo, in_ps, in_sa, in_es, in_msub, in_rm, in_prod, in_tag} = '0;
    {w_flush, w_in_valid, w_out_ready} = '0;
    {w_in_sc, w_in_eo, w_in_ps, w_in_sa, w_in_es, w_in_msub, w_in_rm,
     w_in_prod, w_in_tag} = '0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_payload", {out_sc, out_eo, out_ps, out_sa, out_es, out_msub,
                        out_rm, out_prod, out_tag}, 160'd0);
    chk("rst_w_out_valid", w_out_valid, 1'b0);
    chk("rst_w_prod", w_out_prod, 160'd0);
    rst_n = 1'b1;

    // Directed table: single transfer, backpressure/skid, flush.
    for (int i = 0; i < 19; i++) begin
      b = rand_bnd();
      b.tag = tbl[i].tag;
      if (tbl[i].prod != '0) b.prod = tbl[i].prod;
      drive_check(tbl[i].v, tbl[i].rdy, tbl[i].fl, b);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].er);
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].eocc);
      if (tbl[i].ev) chk($sformatf("tbl%0d_tag", i), out_tag, tbl[i].etag);
      if (i == 2) chk("tbl2_prod", out_prod, 48'h123456789ABC);
      advance(tbl[i].v, tbl[i].rdy, tbl[i].fl, b);
    end

    // Streaming: 16 back-to-back bundles, tags 0..15.
    for (int i = 0; i < 16; i++) begin
      b = rand_bnd();
      b.tag = 8'(i);
      drive_check(1'b1, 1'b1, 1'b0, b);
      chk("stream_in_ready", in_ready, 1'b1);
      if (i > 0) chk("stream_tag", out_tag, 8'(i - 1));
      advance(1'b1, 1'b1, 1'b0, b);
    end
    b = rand_bnd();
    drive_check(1'b0, 1'b1, 1'b0, b);
    chk("stream_last_tag", out_tag, 8'd15);
    advance(1'b0, 1'b1, 1'b0, b);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, rand_bnd());
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, rand_bnd());

    // Asynchronous reset while FULL.
    step(1'b1, 1'b0, 1'b0, rand_bnd());
    step(1'b1, 1'b0, 1'b0, rand_bnd());
    chk("pre_rst_occ", occupancy, 2'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_prod", out_prod, 48'h0);
    chk("arst_occupancy", occupancy, 2'd0);
    chk("arst_in_ready", in_ready, 1'b1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    b = rand_bnd();
    b.tag = 8'h5A;
    b.prod = 48'h123456789ABC;
    step(1'b1, 1'b1, 1'b0, b);
    drive_check(1'b0, 1'b1, 1'b0, rand_bnd());
    chk("post_rst_tag", out_tag, 8'h5A);
    chk("post_rst_occ", occupancy, 2'd1);
    advance(1'b0, 1'b1, 1'b0, b);
    step(1'b0, 1'b1, 1'b0, rand_bnd());

    // Wide instance: streaming then backpressure with an all-ones product.
    for (int i = 0; i < 8; i++) begin
      wb = '0;
      wb.prod = '1;
      wb.sa = (i % 2 == 0) ? 12'hFFF : 12'h800;
      wb.es = 12'(i * 291);
      wb.sc = 5'($urandom());
      wb.rm = 3'(i);
      wb.tag = 1'(i);
      wstep(1'b1, 1'b1, wb);
    end
    wstep(1'b0, 1'b1, wb);
    for (int i = 0; i < 3; i++) begin
      wb = '0;
      wb.prod = '1;
      wb.prod[i] = 1'b0;
      wb.sa = 12'hFFF - 12'(i);
      wb.tag = 1'(i);
      wstep(1'b1, 1'b0, wb);
      if (i == 2) chk("w_bp_occ", w_occupancy, 2'd2);
    end
    for (int i = 0; i < 3; i++) wstep(1'b1, 1'b1, wb);
    for (int i = 0; i < 3; i++) wstep(1'b0, 1'b1, wb);
    chk("w_drained", w_out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
